stream_axi_wr_addr: RTL

Write-side counterpart of the HDMI read address generator: accepts a received pixel stream (1 word = 1 pixel), buffers it in a 2×64-word ping-pong buffer, and issues 64-word write bursts to the AXI write master over the kick/busy handshake, supplying the burst data on request. Sits between the stream receiver and the AXI write master and fills the frame buffer that the HDMI read path later scans out.

---
 rtl/stream_axi_wr_addr_if.sv | 30 +++
 rtl/stream_axi_wr_addr.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_axi_wr_addr_if.sv
// Write-master side bus of stream_axi_wr_addr.
// Carries the kick/busy burst handshake and the burst data pop port.
//   master : burst requester (kick, write_addr, write_num, wdata out)
//   slave  : AXI write master (busy, wdata_req out)
interface stream_axi_wr_addr_if;
  logic        busy;
  logic        kick;
  logic [31:0] write_addr;
  logic [31:0] write_num;
  logic        wdata_req;
  logic [31:0] wdata;

  modport master (
    input  busy,
    input  wdata_req,
    output kick,
    output write_addr,
    output write_num,
    output wdata
  );

  modport slave (
    output busy,
    output wdata_req,
    input  kick,
    input  write_addr,
    input  write_num,
    input  wdata
  );
endinterface

// File: rtl/stream_axi_wr_addr.sv
// Pixel stream to AXI write burst generator with 2x64 ping-pong buffer.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   sof             : start-of-frame pulse
//   pix_valid/_data : pixel stream in, pix_ready accepts
//   wr (master)     : kick/busy burst request, write_addr, write_num,
//                     wdata_req pops wdata
//   overflow        : sticky, a pixel was lost to a full buffer
//   frame_done      : one-cycle pulse when the last burst finishes
module stream_axi_wr_addr #(
  parameter logic [11:0] X_SIZE    = 12'd256,
  parameter logic [11:0] Y_SIZE    = 12'd256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sof,
  input  logic                        pix_valid,
  input  logic [31:0]                 pix_data,
  output logic                        pix_ready,
  stream_axi_wr_addr_if.master        wr,
  output logic                        overflow,
  output logic                        frame_done
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_FILL       = 3'd1;
  localparam logic [2:0] S_ISSUE_IDLE = 3'd2;
  localparam logic [2:0] S_ISSUE      = 3'd3;
  localparam logic [2:0] S_ISSUE_WAIT = 3'd4;
  localparam logic [2:0] S_XFER       = 3'd5;

  localparam logic [31:0] TOTAL  = 32'(X_SIZE) * 32'(Y_SIZE);
  localparam logic [11:0] X_LAST = X_SIZE - 12'd64;
  localparam logic [11:0] Y_LAST = Y_SIZE - 12'd1;

  logic [2:0]  state_q,  state_d;
  logic [11:0] x_q,      x_d;
  logic [11:0] y_q,      y_d;
  logic [31:0] in_cnt_q, in_cnt_d;
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic [5:0]  wr_idx_q, wr_idx_d;
  logic [5:0]  rd_idx_q, rd_idx_d;
  logic [1:0]  full_q,   full_d;
  logic        done_q,   done_d;
  logic        last_q,   last_d;
  logic [31:0] addr_q,   addr_d;
  logic        ovf_q,    ovf_d;
  logic        fd_q,     fd_d;

  logic [31:0] mem_q [128];

  logic active;
  logic room;
  logic ready;
  logic accept;
  logic drop;
  logic pop;

  assign active = (state_q != S_IDLE);
  assign room   = (in_cnt_q < TOTAL);
  assign ready  = active & room & ~full_q[wr_bank_q];
  assign accept = pix_valid & ready;
  // Loss only counts while the frame still expects pixels.
  assign drop   = pix_valid & ~ready & active & room;
  // done_q blocks pops past the 64th word of a burst.
  assign pop    = wr.wdata_req & (state_q == S_XFER) & ~done_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    in_cnt_d  = in_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    full_d    = full_q;
    done_d    = done_q;
    last_d    = last_q;
    addr_d    = addr_q;
    ovf_d     = ovf_q | drop;
    fd_d      = 1'b0;

    if (accept) begin
      in_cnt_d = in_cnt_q + 32'd1;
      wr_idx_d = wr_idx_q + 6'd1;
      if (&wr_idx_q) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    // Accept and pop never touch the same bank's full bit.
    if (pop) begin
      rd_idx_d = rd_idx_q + 6'd1;
      if (&rd_idx_q) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        done_d            = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (sof) begin
          state_d   = S_FILL;
          x_d       = 12'd0;
          y_d       = 12'd0;
          in_cnt_d  = 32'd0;
          wr_bank_d = 1'b0;
          rd_bank_d = 1'b0;
          wr_idx_d  = 6'd0;
          rd_idx_d  = 6'd0;
          full_d    = 2'b00;
          last_d    = 1'b0;
        end
      end
      S_FILL: begin
        if (full_q[rd_bank_q]) state_d = S_ISSUE_IDLE;
      end
      S_ISSUE_IDLE: begin
        addr_d = BASE_ADDR
               + ((32'(y_q) * 32'(X_SIZE)
               + 32'(x_q)) << 2);
        if (!wr.busy) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        done_d = 1'b0;
        last_d = (x_q == X_LAST) && (y_q == Y_LAST);
        if (x_q == X_LAST) begin
          x_d = 12'd0;
          y_d = y_q + 12'd1;
        end else begin
          x_d = x_q + 12'd64;
        end
        state_d = S_ISSUE_WAIT;
      end
      S_ISSUE_WAIT: begin
        if (wr.busy) state_d = S_XFER;
      end
      S_XFER: begin
        if (!wr.busy && done_q) begin
          if (last_q) begin
            state_d = S_IDLE;
            fd_d    = 1'b1;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      x_q       <= 12'd0;
      y_q       <= 12'd0;
      in_cnt_q  <= 32'd0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= 6'd0;
      rd_idx_q  <= 6'd0;
      full_q    <= 2'b00;
      done_q    <= 1'b0;
      last_q    <= 1'b0;
      addr_q    <= 32'd0;
      ovf_q     <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      in_cnt_q  <= in_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      full_q    <= full_d;
      done_q    <= done_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      ovf_q     <= ovf_d;
      fd_q      <= fd_d;
    end
  end

  // Buffer storage needs no reset.
  always_ff @(posedge clk) begin
    if (accept) mem_q[{wr_bank_q, wr_idx_q}] <= pix_data;
  end

  assign pix_ready     = ready;
  assign overflow      = ovf_q;
  assign frame_done    = fd_q;
  assign wr.kick       = (state_q == S_ISSUE)
                       | (state_q == S_ISSUE_WAIT);
  assign wr.write_addr = addr_q;
  assign wr.write_num  = 32'd64;
  assign wr.wdata      = mem_q[{rd_bank_q, rd_idx_q}];

endmodule
